// File: rtl/seg7_scanner.sv
// Four-digit common-anode 7-segment scanner for a 16-bit hex value.
// A frame-latched copy of the value, blanking gaps and leading-zero suppression keep the display tear-free.
module seg7_scanner #(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        value_valid,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [7:0]  out,
    output logic        frame_done
);

    localparam int MAX_T = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam bit HAS_BLANK = (BLANK_TICKS > 0);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;
    localparam state_t FIRST_STATE = HAS_BLANK ? ST_BLANK : ST_SHOW;

    state_t        state_q, state_d;
    logic [1:0]    digit_q, digit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   disp_val_q, disp_val_d;
    logic          lz_en_q, lz_en_d;
    logic          first_q, first_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    out_q, out_d;
    logic          frame_done_q, frame_done_d;
    logic          load;
    logic          suppress;
    logic [3:0]    nib;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        shadow_d = value_valid ? value : shadow_q;
        state_d  = state_q;
        digit_d  = digit_q;
        cnt_d    = cnt_q + 1'b1;
        first_d  = 1'b0;
        load     = 1'b0;

        // The first cycle after reset counts as entering digit 0, so it loads a frame.
        if (first_q) begin
            cnt_d = '0;
            load  = 1'b1;
        end else if (state_q == ST_BLANK) begin
            if (cnt_q == BLANK_LAST) begin
                state_d = ST_SHOW;
                cnt_d   = '0;
            end
        end else if (cnt_q == DIGIT_LAST) begin
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
            state_d = HAS_BLANK ? ST_BLANK : ST_SHOW;
            load    = (digit_q == 2'd3);
        end

        disp_val_d   = load ? (value_valid ? value : shadow_q) : disp_val_q;
        lz_en_d      = load ? blank_lz : lz_en_q;
        frame_done_d = load;

        nib = disp_val_d[{digit_d, 2'b00} +: 4];
        case (digit_d)
            2'd1:    suppress = lz_en_d && (disp_val_d[15:4] == 12'h000);
            2'd2:    suppress = lz_en_d && (disp_val_d[15:8] == 8'h00);
            2'd3:    suppress = lz_en_d && (disp_val_d[15:12] == 4'h0);
            default: suppress = 1'b0;
        endcase

        an_d  = 4'hF;
        out_d = 8'hFF;
        if (state_d == ST_SHOW && !suppress) begin
            an_d  = ~(4'b0001 << digit_d);
            out_d = {~dp_mask[digit_d], seg(nib)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FIRST_STATE;
            digit_q      <= 2'd0;
            cnt_q        <= '0;
            shadow_q     <= 16'h0000;
            disp_val_q   <= 16'h0000;
            lz_en_q      <= 1'b0;
            first_q      <= 1'b1;
            an_q         <= 4'hF;
            out_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            disp_val_q   <= disp_val_d;
            lz_en_q      <= lz_en_d;
            first_q      <= first_d;
            an_q         <= an_d;
            out_q        <= out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign out        = out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// Directed bench for seg7_scanner: one DUT with DIGIT_TICKS=4/BLANK_TICKS=2, one with BLANK_TICKS=0.
// Frames are captured cycle by cycle and compared against hand-computed digit patterns.
module tb_seg7_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        value_valid = 1'b0;
    logic [3:0]  dp_mask = 4'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an, an1;
    logic [7:0]  out, out1;
    logic        frame_done, frame_done1;

    int passed = 0;
    int total  = 0;

    logic [3:0] cap_an[24];
    logic [7:0] cap_out[24];
    logic       cap_fd[25];

    seg7_scanner #(.DIGIT_TICKS(4), .BLANK_TICKS(2)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid),
        .dp_mask(dp_mask), .blank_lz(blank_lz),
        .an(an), .out(out), .frame_done(frame_done)
    );

    seg7_scanner #(.DIGIT_TICKS(4), .BLANK_TICKS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid),
        .dp_mask(dp_mask), .blank_lz(blank_lz),
        .an(an1), .out(out1), .frame_done(frame_done1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // e packs expected segment bytes {d3,d2,d1,d0}; FF marks a dark (suppressed) digit.
    function automatic logic [3:0] exp_an_f(input int k, input logic [31:0] e);
        int d = k / 6;
        logic [7:0] o = e[8*d +: 8];
        if ((k % 6) < 2 || o == 8'hFF) return 4'hF;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [7:0] exp_out_f(input int k, input logic [31:0] e);
        int d = k / 6;
        if ((k % 6) < 2) return 8'hFF;
        return e[8*d +: 8];
    endfunction

    task automatic wait_frame();
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (frame_done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        total++;
        if (seen) passed++;
        else $display("FAIL wait_frame: frame_done not seen within 100 cycles");
    endtask

    // Starts on the cycle frame_done is high and ends on the next frame's first cycle.
    task automatic capture(input int pulse_at, input logic [15:0] pv);
        for (int k = 0; k < 24; k++) begin
            cap_an[k]  = an;
            cap_out[k] = out;
            cap_fd[k]  = frame_done;
            value_valid = (k == pulse_at);
            if (k == pulse_at) value = pv;
            step();
        end
        value_valid = 1'b0;
        cap_fd[24]  = frame_done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (an !== 4'hF || out !== 8'hFF || frame_done !== 1'b0)
                $display("FAIL reset_hold: an=%h out=%h fd=%b, expected an=f out=ff fd=0", an, out, frame_done);
            else passed++;
        end
        rst_n = 1'b1;
        step();
        total++;
        if (frame_done !== 1'b1 || an !== 4'hF || out !== 8'hFF)
            $display("FAIL reset_first: an=%h out=%h fd=%b, expected an=f out=ff fd=1", an, out, frame_done);
        else passed++;
        step();
        total++;
        if (frame_done !== 1'b0 || an !== 4'hF || out !== 8'hFF)
            $display("FAIL reset_blank: an=%h out=%h fd=%b, expected an=f out=ff fd=0", an, out, frame_done);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (an !== 4'hE || out !== 8'hC0)
                $display("FAIL reset_digit0: cycle %0d an=%h out=%h, expected an=e out=c0", i, an, out);
            else passed++;
        end
        step();
        total++;
        if (an !== 4'hF || out !== 8'hFF)
            $display("FAIL reset_gap: an=%h out=%h, expected an=f out=ff", an, out);
        else passed++;
    endtask

    task automatic test_digit_order();
        bit period_ok;
        logic [31:0] e = {8'hF9, 8'h88, 8'hA4, 8'h8E};
        wait_frame();
        capture(3, 16'h1A2F);
        capture(-1, 16'h0000);
        for (int k = 0; k < 24; k++) begin
            total++;
            if (cap_an[k] !== exp_an_f(k, e) || cap_out[k] !== exp_out_f(k, e))
                $display("FAIL digit_order: idx %0d an=%h out=%h, expected an=%h out=%h",
                         k, cap_an[k], cap_out[k], exp_an_f(k, e), exp_out_f(k, e));
            else passed++;
        end
        period_ok = (cap_fd[0] === 1'b1) && (cap_fd[24] === 1'b1);
        for (int k = 1; k < 24; k++) if (cap_fd[k] !== 1'b0) period_ok = 0;
        total++;
        if (!period_ok) $display("FAIL frame_period: frame_done not exactly every 24 cycles (fd[0]=%b fd[24]=%b)", cap_fd[0], cap_fd[24]);
        else passed++;
    endtask

    task automatic test_tear_free();
        logic [31:0] e_old = {4{8'hF9}};
        logic [31:0] e_new = {4{8'hA4}};
        capture(3, 16'h1111);
        capture(9, 16'h2222);
        for (int k = 0; k < 24; k++) begin
            total++;
            if (cap_an[k] !== exp_an_f(k, e_old) || cap_out[k] !== exp_out_f(k, e_old))
                $display("FAIL tear_current: idx %0d an=%h out=%h, expected an=%h out=%h",
                         k, cap_an[k], cap_out[k], exp_an_f(k, e_old), exp_out_f(k, e_old));
            else passed++;
        end
        capture(-1, 16'h0000);
        for (int k = 0; k < 24; k++) begin
            total++;
            if (cap_an[k] !== exp_an_f(k, e_new) || cap_out[k] !== exp_out_f(k, e_new))
                $display("FAIL tear_next: idx %0d an=%h out=%h, expected an=%h out=%h",
                         k, cap_an[k], cap_out[k], exp_an_f(k, e_new), exp_out_f(k, e_new));
            else passed++;
        end
    endtask

    task automatic test_leading_zero();
        logic [31:0] e1 = {8'hFF, 8'hFF, 8'hB0, 8'hC0};
        logic [31:0] e2 = {8'hFF, 8'hFF, 8'hFF, 8'hC0};
        blank_lz = 1'b1;
        capture(3, 16'h0030);
        capture(-1, 16'h0000);
        for (int k = 0; k < 24; k++) begin
            total++;
            if (cap_an[k] !== exp_an_f(k, e1) || cap_out[k] !== exp_out_f(k, e1))
                $display("FAIL lz_0030: idx %0d an=%h out=%h, expected an=%h out=%h",
                         k, cap_an[k], cap_out[k], exp_an_f(k, e1), exp_out_f(k, e1));
            else passed++;
        end
        capture(3, 16'h0000);
        capture(-1, 16'h0000);
        for (int k = 0; k < 24; k++) begin
            total++;
            if (cap_an[k] !== exp_an_f(k, e2) || cap_out[k] !== exp_out_f(k, e2))
                $display("FAIL lz_0000: idx %0d an=%h out=%h, expected an=%h out=%h",
                         k, cap_an[k], cap_out[k], exp_an_f(k, e2), exp_out_f(k, e2));
            else passed++;
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_decimal_point();
        logic [31:0] e = {8'h80, 8'h00, 8'h80, 8'h80};
        dp_mask = 4'b0100;
        capture(3, 16'h8888);
        capture(-1, 16'h0000);
        for (int k = 0; k < 24; k++) begin
            total++;
            if (cap_an[k] !== exp_an_f(k, e) || cap_out[k] !== exp_out_f(k, e))
                $display("FAIL decimal_point: idx %0d an=%h out=%h, expected an=%h out=%h",
                         k, cap_an[k], cap_out[k], exp_an_f(k, e), exp_out_f(k, e));
            else passed++;
        end
        dp_mask = 4'h0;
    endtask

    task automatic test_bypass();
        logic [31:0] e = {8'h92, 8'h88, 8'h92, 8'h88};
        capture(23, 16'h5A5A);
        capture(-1, 16'h0000);
        for (int k = 0; k < 24; k++) begin
            total++;
            if (cap_an[k] !== exp_an_f(k, e) || cap_out[k] !== exp_out_f(k, e))
                $display("FAIL bypass: idx %0d an=%h out=%h, expected an=%h out=%h",
                         k, cap_an[k], cap_out[k], exp_an_f(k, e), exp_out_f(k, e));
            else passed++;
        end
    endtask

    task automatic test_no_blank();
        bit seen = 0;
        logic [7:0] exp_o[4] = '{8'h88, 8'h92, 8'h88, 8'h92};
        for (int i = 0; i < 100; i++) begin
            step();
            if (frame_done1 === 1'b1) begin
                seen = 1;
                break;
            end
        end
        total++;
        if (!seen) $display("FAIL no_blank_frame: frame_done not seen within 100 cycles");
        else passed++;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] ea = ~(4'b0001 << (k / 4));
            total++;
            if (an1 !== ea || out1 !== exp_o[k / 4])
                $display("FAIL no_blank: idx %0d an=%h out=%h, expected an=%h out=%h", k, an1, out1, ea, exp_o[k / 4]);
            else passed++;
            step();
        end
        total++;
        if (frame_done1 !== 1'b1)
            $display("FAIL no_blank_period: fd=%b at cycle 16, expected 1", frame_done1);
        else passed++;
    endtask

    task automatic test_reset_mid_show();
        wait_frame();
        for (int i = 0; i < 15; i++) step();
        total++;
        if (an !== 4'hB)
            $display("FAIL mid_show_pos: an=%h, expected b", an);
        else passed++;
        rst_n = 1'b0;
        step();
        total++;
        if (an !== 4'hF || out !== 8'hFF || frame_done !== 1'b0)
            $display("FAIL mid_reset: an=%h out=%h fd=%b, expected an=f out=ff fd=0", an, out, frame_done);
        else passed++;
        rst_n = 1'b1;
        step();
        total++;
        if (frame_done !== 1'b1 || an !== 4'hF)
            $display("FAIL mid_restart: an=%h fd=%b, expected an=f fd=1", an, frame_done);
        else passed++;
        step();
        step();
        total++;
        if (an !== 4'hE || out !== 8'hC0)
            $display("FAIL mid_digit0: an=%h out=%h, expected an=e out=c0", an, out);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_digit_order();
        test_tear_free();
        test_leading_zero();
        test_decimal_point();
        test_bypass();
        test_no_blank();
        test_reset_mid_show();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
